// File: rtl/data_mem_io_pkg.sv
// Shared constants and types for the MEM-stage data responder:
// the I/O address map, status bit positions and the UART FSM states.
package data_mem_io_pkg;

    localparam logic [7:0] ADDR_LED       = 8'hFC;
    localparam logic [7:0] ADDR_UART_DATA = 8'hFD;
    localparam logic [7:0] ADDR_UART_STAT = 8'hFE;
    localparam logic [7:0] RAM_TOP        = 8'hFB;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_HOLD_FULL = 1;
    localparam int STAT_OVERFLOW  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

endpackage

// File: rtl/uart_tx_buf.sv
// 8N1 UART transmitter with one holding byte behind the shift register,
// giving back-to-back frames and a sticky overflow flag for dropped bytes.
module uart_tx_buf
    import data_mem_io_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       tx,
    output logic       busy,
    output logic       hold_full,
    output logic       overflow
);

    uart_state_t state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic [7:0]  hold;
    logic        bit_end;
    logic        frame_end;

    assign bit_end   = (baud_cnt == 16'(BAUD_DIV - 1));
    assign frame_end = (state == STOP) && bit_end;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (clr_ovf)
                overflow <= 1'b0;

            // At the end of STOP the write is absorbed by the reload below
            if (wr && busy && !frame_end) begin
                if (!hold_full) begin
                    hold      <= wr_data;
                    hold_full <= 1'b1;
                end else begin
                    overflow  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (wr) begin
                        shift    <= wr_data;
                        state    <= START;
                        tx       <= 1'b0;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // Held byte goes first; a same-edge write refills hold
                        if (hold_full) begin
                            shift     <= hold;
                            state     <= START;
                            tx        <= 1'b0;
                            hold_full <= wr;
                            if (wr)
                                hold <= wr_data;
                        end else if (wr) begin
                            shift <= wr_data;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_io.sv
// Data-side responder for the CPU MEM stage: 252-byte RAM, LED register
// and a buffered UART transmitter mapped into the top of the address space.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] addr,
    input  logic [7:0] w_data,
    input  logic       w_en,
    output logic [7:0] r_data,
    output logic [7:0] led,
    output logic       uart_tx
);

    logic [7:0] ram [0:251];
    logic       uart_wr;
    logic       clr_ovf;
    logic       busy;
    logic       hold_full;
    logic       overflow;
    logic [7:0] status;

    assign uart_wr = w_en && (addr == ADDR_UART_DATA);
    assign clr_ovf = w_en && (addr == ADDR_UART_STAT) && w_data[STAT_OVERFLOW];

    // RAM is deliberately left out of reset so it maps onto block memory
    always_ff @(posedge clock) begin
        if (w_en && (addr <= RAM_TOP))
            ram[addr] <= w_data;
    end

    always_ff @(posedge clock) begin
        if (reset)
            led <= 8'h00;
        else if (w_en && (addr == ADDR_LED))
            led <= w_data;
    end

    always_comb begin
        status                 = 8'h00;
        status[STAT_BUSY]      = busy;
        status[STAT_HOLD_FULL] = hold_full;
        status[STAT_OVERFLOW]  = overflow;
    end

    always_comb begin
        r_data = 8'h00;
        if (addr <= RAM_TOP) begin
            r_data = ram[addr];
        end else begin
            case (addr)
                ADDR_LED:       r_data = led;
                ADDR_UART_STAT: r_data = status;
                default:        r_data = 8'h00;
            endcase
        end
    end

    uart_tx_buf #(
        .BAUD_DIV(BAUD_DIV)
    ) u_uart (
        .clock    (clock),
        .reset    (reset),
        .wr       (uart_wr),
        .wr_data  (w_data),
        .clr_ovf  (clr_ovf),
        .tx       (uart_tx),
        .busy     (busy),
        .hold_full(hold_full),
        .overflow (overflow)
    );

endmodule
